// File: rtl/mult_ctrl_pkg.sv
// Shared constants for the sequential-multiplier scheduler: FSM state codes,
// the default operand width and the two-way round-robin pick.
package mult_ctrl_pkg;

  localparam int MULT_W = 6;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // A lone requester always wins; on a tie the pointer holder wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
    logic [1:0] grant;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
    return grant;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Purely combinational; the pointer is owned by
// the caller, and no grant is issued unless update is asserted.
module rr_arb2
  import mult_ctrl_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  input  logic       i_update,
  output logic [1:0] o_grant
);

  // One-hot grant, or zero when not arbitrating
  always_comb begin
    o_grant = 2'b00;
    if (i_update) begin
      o_grant = rr_pick(i_req, i_ptr);
    end else begin
      o_grant = 2'b00;
    end
  end

endmodule

// File: rtl/seq_mult_sched.sv
// Schedules one shared right-shift multiplier between two requesters:
// arbitrate, load, iterate WIDTH cycles, capture, then pulse done to the owner.
module seq_mult_sched
  import mult_ctrl_pkg::*;
#(
  parameter int WIDTH = MULT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [WIDTH-1:0]     a0,
  input  logic [WIDTH-1:0]     a1,
  input  logic [WIDTH-1:0]     b0,
  input  logic [WIDTH-1:0]     b1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 done0,
  output logic                 done1,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy,
  output logic                 mul_load,
  output logic                 mul_hold,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic [2*WIDTH-1:0]   mul_product
);

  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]           r_state;
  logic [1:0]           w_next_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_ptr;
  logic                 r_owner;
  logic [1:0]           r_gnt;
  logic [1:0]           r_done;
  logic [2*WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]     r_mul_a;
  logic [WIDTH-1:0]     r_mul_b;
  logic [1:0]           w_grant;
  logic                 w_arb_update;
  logic                 w_mul_load;
  logic                 w_mul_hold;
  logic                 w_busy;

  // Arbitration only happens in IDLE, which includes the done-pulse cycle
  assign w_arb_update = (r_state == S_IDLE);

  rr_arb2 u_arb (
    .i_req    ({req1, req0}),
    .i_ptr    (r_ptr),
    .i_update (w_arb_update),
    .o_grant  (w_grant)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant != 2'b00) begin
          w_next_state = S_LOAD;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_LOAD: w_next_state = S_RUN;
      S_RUN: begin
        if (r_cnt == CNT_LAST) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_RUN;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs: multiplier control and busy, decoded from the state register
  always_comb begin
    w_mul_load = 1'b0;
    w_mul_hold = 1'b1;
    w_busy     = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_mul_load = 1'b0;
        w_mul_hold = 1'b1;
        w_busy     = 1'b0;
      end
      S_LOAD: begin
        w_mul_load = 1'b1;
        w_mul_hold = 1'b0;
        w_busy     = 1'b1;
      end
      S_RUN: begin
        w_mul_load = 1'b0;
        w_mul_hold = 1'b0;
        w_busy     = 1'b1;
      end
      S_DONE: begin
        w_mul_load = 1'b0;
        w_mul_hold = 1'b1;
        w_busy     = 1'b1;
      end
      default: begin
        w_mul_load = 1'b0;
        w_mul_hold = 1'b1;
        w_busy     = 1'b0;
      end
    endcase
  end

  // Job datapath: operand latch, iteration count, grant/done, result, pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= {CNT_W{1'b0}};
      r_ptr    <= 1'b0;
      r_owner  <= 1'b0;
      r_gnt    <= 2'b00;
      r_done   <= 2'b00;
      r_result <= {(2*WIDTH){1'b0}};
      r_mul_a  <= {WIDTH{1'b0}};
      r_mul_b  <= {WIDTH{1'b0}};
    end else begin
      r_done <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (w_grant != 2'b00) begin
            r_gnt   <= w_grant;
            r_owner <= w_grant[1];
            r_mul_a <= w_grant[1] ? a1 : a0;
            r_mul_b <= w_grant[1] ? b1 : b0;
          end else begin
            r_gnt <= 2'b00;
          end
        end
        S_LOAD: begin
          r_cnt <= {CNT_W{1'b0}};
        end
        S_RUN: begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_DONE: begin
          // The done pulse lands in the following IDLE cycle
          r_result <= mul_product;
          r_done   <= r_gnt;
          r_gnt    <= 2'b00;
          r_ptr    <= ~r_owner;
        end
        default: begin
          r_gnt <= 2'b00;
        end
      endcase
    end
  end

  assign gnt0     = r_gnt[0];
  assign gnt1     = r_gnt[1];
  assign done0    = r_done[0];
  assign done1    = r_done[1];
  assign result   = r_result;
  assign busy     = w_busy;
  assign mul_load = w_mul_load;
  assign mul_hold = w_mul_hold;
  assign mul_a    = r_mul_a;
  assign mul_b    = r_mul_b;

endmodule

// File: tb/tb_seq_mult_sched.sv
// Self-checking bench for seq_mult_sched with a real shift-add multiplier and
// a reference model of latency, round-robin ownership and products.
module tb_seq_mult_sched;
  import mult_ctrl_pkg::*;

  localparam int W   = MULT_W;
  localparam int LAT = W + 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, req1;
  logic [W-1:0]     a0, a1, b0, b1;
  logic             gnt0, gnt1, done0, done1, busy, mul_load, mul_hold;
  logic [2*W-1:0]   result, mul_product;
  logic [W-1:0]     mul_a, mul_b;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;

  always #5 clk = ~clk;

  seq_mult_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .busy(busy), .mul_load(mul_load), .mul_hold(mul_hold),
    .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product)
  );

  // Unsigned right-shift multiplier: add multiplicand on LSB, then shift
  logic [2*W-1:0] r_p;
  logic [W-1:0]   r_mc;
  logic [W:0]     w_sum;
  assign w_sum = {1'b0, r_p[2*W-1:W]} + (r_p[0] ? {1'b0, r_mc} : {(W+1){1'b0}});
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p  <= '0;
      r_mc <= '0;
    end else if (mul_load) begin
      r_p  <= {{W{1'b0}}, mul_b};
      r_mc <= mul_a;
    end else if (!mul_hold) begin
      r_p <= {w_sum, r_p[W-1:1]};
    end
  end
  assign mul_product = r_p;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_gnt"},   32'({gnt1, gnt0}), 32'd0);
    chk({tag, "_done"},  32'({done1, done0}), 32'd0);
    chk({tag, "_res"},   32'(result), 32'd0);
    chk({tag, "_load"},  32'(mul_load), 32'd0);
    chk({tag, "_hold"},  32'(mul_hold), 32'd1);
    chk({tag, "_mula"},  32'(mul_a), 32'd0);
    chk({tag, "_mulb"},  32'(mul_b), 32'd0);
  endtask

  // Follow one job from grant to done pulse; expectations come from the job timeline
  task automatic expect_done(input int owner, input bit drop, input bit perturb);
    logic [W-1:0]   ea, eb;
    logic [2*W-1:0] eres;
    logic [1:0]     onehot;
    int n;
    bit seen;
    ea     = (owner == 1) ? a1 : a0;
    eb     = (owner == 1) ? b1 : b0;
    eres   = (2*W)'(ea) * (2*W)'(eb);
    onehot = (owner == 1) ? 2'b10 : 2'b01;
    n      = 0;
    seen   = 1'b0;
    while (!seen && n < LAT + 20) begin
      tick();
      n++;
      if (perturb && n == 2) a0 = W'(1);
      if (perturb && n == 3) req0 = 1'b0;
      seen = done0 | done1;
      if (n <= LAT) begin
        chk("busy", 32'(busy), 32'(n < LAT));
        chk("gnt",  32'({gnt1, gnt0}), (n < LAT) ? 32'(onehot) : 32'd0);
        chk("mul_load", 32'(mul_load), 32'(n == 1));
        chk("mul_hold", 32'(mul_hold), 32'(n >= W + 2));
      end
      if (n == 1) begin
        chk("mul_a", 32'(mul_a), 32'(ea));
        chk("mul_b", 32'(mul_b), 32'(eb));
      end
    end
    chk("latency", 32'(n), 32'(LAT));
    chk("done_owner", 32'({done1, done0}), 32'(onehot));
    chk("result", 32'(result), 32'(eres));
    m_ptr = 1 - owner;
    if (drop) begin
      if (owner == 1) req1 = 1'b0;
      else            req0 = 1'b0;
    end
  endtask

  initial begin
    int order[4];
    int pat;
    int first;
    bit any_evt;
    order = '{0, 1, 0, 1};
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    #1 rst = 1'b1;
    tick(); tick();
    chk_cleared("reset");
    rst = 1'b0;
    tick();

    // Single requester 0
    a0 = W'(29); b0 = W'(13); req0 = 1'b1;
    expect_done(0, 1'b1, 1'b0);
    chk("t1_377", 32'(result), 32'd377);

    // Requester 1: all-ones operands, then zero operand
    a1 = W'(63); b1 = W'(63); req1 = 1'b1;
    expect_done(1, 1'b1, 1'b0);
    chk("t2_3969", 32'(result), 32'd3969);
    a1 = W'(0); b1 = W'(45); req1 = 1'b1;
    expect_done(1, 1'b1, 1'b0);
    chk("t2_zero", 32'(result), 32'd0);
    tick();
    chk("t2_single_done", 32'({done1, done0}), 32'd0);

    // Simultaneous requests right after reset
    rst = 1'b1; tick(); rst = 1'b0; m_ptr = 0;
    a0 = W'(5); b0 = W'(7); a1 = W'(9); b1 = W'(11);
    req0 = 1'b1; req1 = 1'b1;
    expect_done(0, 1'b1, 1'b0);
    chk("t3_35", 32'(result), 32'd35);
    expect_done(1, 1'b1, 1'b0);
    chk("t3_99", 32'(result), 32'd99);

    // Both held for four jobs: owners must alternate
    a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
    req0 = 1'b1; req1 = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("t4_model_ptr", 32'(m_ptr), 32'(order[j]));
      expect_done(order[j], j == 3, 1'b0);
    end
    req0 = 1'b0; req1 = 1'b0;

    // Operand change and request drop mid-job
    a0 = W'(29); b0 = W'(13); req0 = 1'b1;
    expect_done(0, 1'b1, 1'b1);
    chk("t6_377", 32'(result), 32'd377);

    // Randomized request patterns against the round-robin model
    for (int r = 0; r < 10; r++) begin
      pat = $urandom_range(3, 1);
      a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
      req0 = pat[0]; req1 = pat[1];
      if (pat == 3) begin
        first = m_ptr;
        expect_done(first, 1'b1, 1'b0);
        expect_done(1 - first, 1'b1, 1'b0);
      end else begin
        expect_done((pat == 2) ? 1 : 0, 1'b1, 1'b0);
      end
    end

    // Reset during the third RUN cycle
    a0 = W'(20); b0 = W'(30); req0 = 1'b1;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1 chk_cleared("midrst");
    req0 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    any_evt = 1'b0;
    repeat (LAT + 5) begin
      tick();
      any_evt = any_evt | done0 | done1 | busy;
    end
    chk("t5_no_done", 32'(any_evt), 32'd0);
    m_ptr = 0;
    a0 = W'(2); b0 = W'(3); req0 = 1'b1;
    expect_done(0, 1'b1, 1'b0);
    chk("t5_6", 32'(result), 32'd6);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
